operand_loader: RTL

- Upstream operand-capture stage for the 2-bit operand selector and ALU path.
- Captures operand A, then operand B, from one shared switch bus, one value per debounced load press.
- Holds both operands stable and flags them valid for the downstream selector/ALU, which consumes them with an ack.
- Also counts completed operand pairs for display.

---
 rtl/operand_pkg.sv | 11 +
 rtl/rise_detect.sv | 18 +
 rtl/operand_loader.sv | 97 +++++++++
 3 files changed

// File: rtl/operand_pkg.sv
// Shared definitions for the operand capture path: default widths and FSM state encoding.
package operand_pkg;
  localparam int WIDTH_DEF = 2;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    READY  = 2'b10
  } state_t;
endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the level input and pulses 'rise' for one cycle on 0->1.
// Zero latency from input to pulse; no backpressure (a level held high yields one pulse).
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);
  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  // Cleared history makes a level already high right after reset count as a rise.
  assign rise = level & ~level_q;
endmodule

// File: rtl/operand_loader.sv
// Captures operand A then B from a shared bus, one per load press; holds the pair valid until ack.
// din captured on the edge where load is first seen high; pair held until ack, clear or a new press.
module operand_loader
  import operand_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             ack,
  input  logic             clear,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             valid,
  output logic             busy,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] pair_cnt
);
  state_t           state_q, state_n;
  logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             valid_q, busy_q;
  logic             load_rise;

  rise_detect u_load_rise (
    .clk   (clk),
    .rst   (rst),
    .level (load),
    .rise  (load_rise)
  );

  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    cnt_n   = cnt_q;
    if (clear) begin
      state_n = LOAD_A;
      a_n     = '0;
      b_n     = '0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (load_rise) begin
            a_n     = din;
            state_n = LOAD_B;
          end
        end
        LOAD_B: begin
          if (load_rise) begin
            b_n     = din;
            cnt_n   = cnt_q + CNT_W'(1);
            state_n = READY;
          end
        end
        READY: begin
          // A new press restarts the pair and wins over a same-cycle ack.
          if (load_rise) begin
            a_n     = din;
            state_n = LOAD_B;
          end else if (ack) begin
            state_n = LOAD_A;
          end
        end
        default: state_n = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      cnt_q   <= cnt_n;
      valid_q <= (state_n == READY);
      busy_q  <= (state_n == LOAD_B);
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign state    = state_q;
  assign pair_cnt = cnt_q;
endmodule
